sonar_adc_capture_controller: RTL and testbench
===============================================

SONAR_ADC_CAPTURE_CONTROLLER -- requirements
Module: sonar_adc_capture_controller

Interface
REQ-001 The block SHALL have one parameter, CLK_DIV, default 4: the SCLK half-period in clk cycles, legal range 2..255.
REQ-002 The block SHALL have the port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port `start`, input, 1 bit: request one 16-bit capture; it is sampled only in IDLE.
REQ-005 The block SHALL have the port `continuous`, input, 1 bit: when high, a new capture starts automatically after QUIET.
REQ-006 The block SHALL have the port `sdata`, input, 1 bit: the ADC serial data, MSB first, sampled on SCLK rising edges.
REQ-007 The block SHALL have the port `sr_q`, input, 16 bits: the parallel output of the external 16-bit enabled shift register, where q[0] holds the newest bit.
REQ-008 The block SHALL have the port `sr_enable`, output, 1 bit: the shift enable to the external register, a one-clk pulse per captured bit.
REQ-009 The block SHALL have the port `sr_d`, output, 1 bit: the serial bit presented to the external register's d input.
REQ-010 The block SHALL have the port `cs_n`, output, 1 bit: the ADC chip select, active-low.
REQ-011 The block SHALL have the port `sclk`, output, 1 bit: the ADC serial clock.
REQ-012 The block SHALL have the port `word_out`, output, 16 bits: the last completed sample.
REQ-013 The block SHALL have the port `word_valid`, output, 1 bit: a one-cycle pulse when `word_out` updates.
REQ-014 The block SHALL have the port `busy`, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have the port `word_count`, output, 16 bits: the number of completed captures, wrapping modulo 2^16.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT, DONE and QUIET; no other state is reachable.
REQ-017 IDLE SHALL behave as follows: cs_n=1, sclk=0; the FSM goes to SETUP on the cycle after start=1 or continuous=1 is sampled.
REQ-018 SETUP SHALL behave as follows: cs_n=0, sclk=0; it lasts exactly CLK_DIV cycles, then goes to SHIFT.
REQ-019 SHIFT SHALL behave as follows: cs_n=0; a divider counts 0..CLK_DIV-1 and sclk toggles when the count reaches CLK_DIV-1; sclk starts low; SHIFT lasts exactly 32*CLK_DIV cycles (16 full SCLK periods); sclk is low on exit.
REQ-020 On each SCLK 0->1 transition, the block SHALL assert sr_enable for exactly one clk cycle, and sr_d SHALL equal sdata registered in the same cycle sclk rises.
REQ-021 sr_enable SHALL pulse exactly 16 times per capture, and never outside SHIFT.
REQ-022 DONE SHALL last one cycle: word_out<=sr_q, word_valid=1, word_count<=word_count+1 (wrapping 0xFFFF->0x0000), cs_n=1.
REQ-023 QUIET SHALL behave as follows: cs_n=1, sclk=0; it lasts CLK_DIV cycles, then goes to SETUP if continuous=1, else to IDLE.
REQ-024 Start-to-valid latency SHALL be 1 + CLK_DIV + 32*CLK_DIV cycles from the start-sampling edge to word_valid.
REQ-025 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 Dropping continuous mid-capture SHALL complete the current capture, then return to IDLE.
REQ-027 start and continuous both high in IDLE SHALL cause a single transition to SETUP.
REQ-028 word_out SHALL hold its value between DONE cycles, and SHALL NOT change outside DONE.
REQ-029 The block SHALL NOT reset the external shift register; correctness relies on all 16 bits being shifted per capture.

Reset
REQ-030 On the clk edge where reset=1, the block SHALL set: state=IDLE, cs_n=1, sclk=0, sr_enable=0, sr_d=0, word_out=0x0000, word_valid=0, busy=0, word_count=0x0000, and divider and bit counters to 0.
REQ-031 reset SHALL override every state, including mid-SHIFT: the capture is abandoned, word_valid is not pulsed, and word_count is unchanged apart from its reset to 0.
REQ-032 start sampled in the first cycle after reset deasserts SHALL be honoured.

Verification
REQ-033 A single capture SHALL be verified: CLK_DIV=2, start pulsed at cycle 0, sdata driving 0xA5C3 MSB-first on SCLK rises -> cs_n low at cycles 1..66, 16 sr_enable pulses, word_valid only at cycle 67, word_out=0xA5C3, word_count=1, busy low from cycle 70.
REQ-034 Ignored start SHALL be verified: start re-pulsed at cycles 10 and 40 during the above capture -> exactly one word_valid, and busy returns to 0 at cycle 70.
REQ-035 Continuous mode SHALL be verified: continuous=1, CLK_DIV=2, sdata=1 constant -> word_valid every 69 cycles, word_out=0xFFFF, cs_n high for exactly 3 cycles between captures.
REQ-036 Reset mid-SHIFT SHALL be verified: reset asserted at cycle 30 -> on the next edge cs_n=1, sclk=0, word_count=0, and no word_valid appears; a subsequent start yields a correct 16-bit word.
REQ-037 Counter wrap SHALL be verified: word_count forced through 65535 captures (or preloaded by bench backdoor) -> the next DONE gives word_count=0x0000.
REQ-038 The divider SHALL be verified: CLK_DIV=5 -> sclk high and low phases are each exactly 5 cycles, and SHIFT lasts 160 cycles.

Source files
------------

// File: rtl/sonar_adc_capture_controller.sv
// Serial ADC capture controller: drives CS/SCLK, feeds an external 16-bit shift
// register one bit per SCLK rise, and latches the finished word after 16 bits.
module sonar_adc_capture_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        sdata,
  input  logic [15:0] sr_q,
  output logic        sr_enable,
  output logic        sr_d,
  output logic        cs_n,
  output logic        sclk,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        busy,
  output logic [15:0] word_count
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned HALF_W = 5;
  localparam int unsigned WORD_W = 16;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(31);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0]  div, div_next;
  logic [HALF_W-1:0] half, half_next;
  logic              div_end;
  logic              sclk_next, sr_enable_next, sr_d_next, cs_n_next;
  logic              word_valid_next, busy_next;
  logic [WORD_W-1:0] word_out_next, word_count_next;

  assign div_end = (div == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; half counts SCLK half-periods, 32 of them per capture
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start || continuous) state_next = SETUP;
      SETUP:   if (div_end) state_next = SHIFT;
      SHIFT:   if (div_end && (half == HALF_LAST)) state_next = DONE;
      DONE:    state_next = QUIET;
      QUIET:   if (div_end) state_next = continuous ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values, registered below so outputs align with state
  always_comb begin
    div_next        = '0;
    half_next       = '0;
    sclk_next       = 1'b0;
    sr_enable_next  = 1'b0;
    sr_d_next       = sr_d;
    word_valid_next = 1'b0;
    word_out_next   = word_out;
    word_count_next = word_count;
    cs_n_next       = !((state_next == SETUP) || (state_next == SHIFT));
    busy_next       = (state_next != IDLE);

    case (state)
      SETUP, QUIET: div_next = div_end ? '0 : div + DIV_W'(1);
      SHIFT: begin
        div_next  = div_end ? '0 : div + DIV_W'(1);
        half_next = div_end ? half + HALF_W'(1) : half;
        sclk_next = div_end ? ~sclk : sclk;
        // A rising SCLK samples the ADC bit and shifts it into the external register
        if (div_end && !sclk) begin
          sr_enable_next = 1'b1;
          sr_d_next      = sdata;
        end
      end
      default: ;
    endcase

    // Word is complete in sr_q by now: the last shift happened CLK_DIV-1 cycles ago
    if (state_next == DONE) begin
      word_valid_next = 1'b1;
      word_out_next   = sr_q;
      word_count_next = word_count + WORD_W'(1);
    end
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      half       <= '0;
      sclk       <= 1'b0;
      sr_enable  <= 1'b0;
      sr_d       <= 1'b0;
      cs_n       <= 1'b1;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      div        <= div_next;
      half       <= half_next;
      sclk       <= sclk_next;
      sr_enable  <= sr_enable_next;
      sr_d       <= sr_d_next;
      cs_n       <= cs_n_next;
      word_out   <= word_out_next;
      word_valid <= word_valid_next;
      busy       <= busy_next;
      word_count <= word_count_next;
    end
  end

endmodule

// File: tb/tb_sonar_adc_capture_controller.sv
// Bench for sonar_adc_capture_controller: two instances (CLK_DIV 2 and 5),
// a behavioural ADC feeder and shift-register model, cycle-by-cycle expectations.
module tb_sonar_adc_capture_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, continuous = 1'b0, sdata = 1'b0;
  logic [15:0] sr_q_a = 16'h5A5A, sr_q_b = 16'hC3C3;
  logic sr_enable_a, sr_d_a, cs_n_a, sclk_a, word_valid_a, busy_a;
  logic sr_enable_b, sr_d_b, cs_n_b, sclk_b, word_valid_b, busy_b;
  logic [15:0] word_out_a, word_count_a, word_out_b, word_count_b;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] cap_words [4];
  logic [15:0] m_cnt [2];
  logic [15:0] m_word [2];

  always #5 clk = ~clk;

  sonar_adc_capture_controller #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .continuous(continuous),
    .sdata(sdata), .sr_q(sr_q_a), .sr_enable(sr_enable_a), .sr_d(sr_d_a),
    .cs_n(cs_n_a), .sclk(sclk_a), .word_out(word_out_a),
    .word_valid(word_valid_a), .busy(busy_a), .word_count(word_count_a));

  sonar_adc_capture_controller #(.CLK_DIV(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .continuous(1'b0),
    .sdata(sdata), .sr_q(sr_q_b), .sr_enable(sr_enable_b), .sr_d(sr_d_b),
    .cs_n(cs_n_b), .sclk(sclk_b), .word_out(word_out_b),
    .word_valid(word_valid_b), .busy(busy_b), .word_count(word_count_b));

  // External enabled shift registers, never reset
  always @(posedge clk) if (sr_enable_a) sr_q_a <= {sr_q_a[14:0], sr_d_a};
  always @(posedge clk) if (sr_enable_b) sr_q_b <= {sr_q_b[14:0], sr_d_b};

  // Runs ncap captures starting from an IDLE cycle n=0; capture period is
  // SETUP(d) + SHIFT(32d) + DONE(1) + QUIET(d). Cycle n is observed at its negedge.
  task automatic run_capture(input int s, input int ncap, input bit use_start,
                             input bit cont, input int drop_at, input int rp1,
                             input int rp2, input bit const_one, input int tail);
    int d, per, total, r, k, p, done_cnt, m;
    int rises, valids, low_cs, sclk_hi, run_len;
    bit e_cs, e_sclk, e_en, e_valid, e_busy, e_bit, active, seen_rise, prev_sclk;
    logic o_cs, o_sclk, o_en, o_d, o_valid, o_busy;
    logic [15:0] o_word, o_cnt, e_word, e_cnt;
    d = (s == 0) ? 2 : 5;
    per = 34 * d + 1;
    total = ncap * per;
    rises = 0; valids = 0; low_cs = 0; sclk_hi = 0; run_len = 0;
    seen_rise = 0; prev_sclk = 0;
    for (int n = 0; n <= total + tail; n++) begin
      o_cs = s ? cs_n_b : cs_n_a;       o_sclk = s ? sclk_b : sclk_a;
      o_en = s ? sr_enable_b : sr_enable_a; o_d = s ? sr_d_b : sr_d_a;
      o_valid = s ? word_valid_b : word_valid_a; o_busy = s ? busy_b : busy_a;
      o_word = s ? word_out_b : word_out_a; o_cnt = s ? word_count_b : word_count_a;
      active = (n >= 1) && (n - 1 < total);
      e_cs = 1; e_sclk = 0; e_en = 0; e_valid = 0; e_busy = active; e_bit = 0;
      if (active) begin
        r = (n - 1) % per; k = (n - 1) / per;
        if (r < d) e_cs = 0;
        else if (r < 33 * d) begin
          e_cs = 0; p = r - d;
          e_sclk = ((p / d) % 2) == 1;
          e_en = (p % (2 * d)) == d;
          e_bit = cap_words[k][15 - p / (2 * d)];
        end else if (r == 33 * d) e_valid = 1;
      end
      done_cnt = (n >= 1 + 33 * d) ? ((n - 1 - 33 * d) / per + 1) : 0;
      if (done_cnt > ncap) done_cnt = ncap;
      e_word = (done_cnt > 0) ? cap_words[done_cnt - 1] : m_word[s];
      e_cnt = m_cnt[s] + 16'(done_cnt);

      n_checks++; if (o_cs !== e_cs) begin n_fail++;
        $display("FAIL cs_n d=%0d n=%0d got=%b exp=%b", d, n, o_cs, e_cs); end
      n_checks++; if (o_sclk !== e_sclk) begin n_fail++;
        $display("FAIL sclk d=%0d n=%0d got=%b exp=%b", d, n, o_sclk, e_sclk); end
      n_checks++; if (o_en !== e_en) begin n_fail++;
        $display("FAIL sr_enable d=%0d n=%0d got=%b exp=%b", d, n, o_en, e_en); end
      if (e_en) begin n_checks++; if (o_d !== e_bit) begin n_fail++;
        $display("FAIL sr_d d=%0d n=%0d got=%b exp=%b", d, n, o_d, e_bit); end end
      n_checks++; if (o_valid !== e_valid) begin n_fail++;
        $display("FAIL word_valid d=%0d n=%0d got=%b exp=%b", d, n, o_valid, e_valid); end
      n_checks++; if (o_busy !== e_busy) begin n_fail++;
        $display("FAIL busy d=%0d n=%0d got=%b exp=%b", d, n, o_busy, e_busy); end
      n_checks++; if (o_word !== e_word) begin n_fail++;
        $display("FAIL word_out d=%0d n=%0d got=%h exp=%h", d, n, o_word, e_word); end
      n_checks++; if (o_cnt !== e_cnt) begin n_fail++;
        $display("FAIL word_count d=%0d n=%0d got=%h exp=%h", d, n, o_cnt, e_cnt); end

      // SCLK phase lengths inside a capture
      if (o_sclk !== prev_sclk) begin
        if (prev_sclk || seen_rise) begin
          n_checks++; if (run_len != d) begin n_fail++;
            $display("FAIL sclk_phase d=%0d n=%0d got=%0d exp=%0d", d, n, run_len, d); end
        end
        if (o_sclk) seen_rise = 1;
        run_len = 1;
      end else run_len++;
      if (o_cs) seen_rise = 0;
      prev_sclk = o_sclk;
      rises += int'(o_en); valids += int'(o_valid);
      low_cs += int'(!o_cs); sclk_hi += int'(o_sclk);

      // Drive inputs for cycle n; sdata carries the bit sampled at the next SCLK rise
      if (s == 0) start_a = use_start && ((n == 0) || (n == rp1) || (n == rp2));
      else        start_b = use_start && ((n == 0) || (n == rp1) || (n == rp2));
      continuous = cont && (n < drop_at);
      sdata = 1'($urandom);
      m = n + 1;
      if ((m >= 1) && (m - 1 < total)) begin
        r = (m - 1) % per; k = (m - 1) / per; p = r - d;
        if ((r >= d) && (r < 33 * d) && ((p % (2 * d)) == d))
          sdata = cap_words[k][15 - p / (2 * d)];
      end
      if (const_one) sdata = 1'b1;
      @(negedge clk);
    end
    start_a = 0; start_b = 0; continuous = 0;
    n_checks++; if (rises != 16 * ncap) begin n_fail++;
      $display("FAIL enable_pulses d=%0d got=%0d exp=%0d", d, rises, 16 * ncap); end
    n_checks++; if (valids != ncap) begin n_fail++;
      $display("FAIL valid_pulses d=%0d got=%0d exp=%0d", d, valids, ncap); end
    n_checks++; if (low_cs != 33 * d * ncap) begin n_fail++;
      $display("FAIL cs_low_cycles d=%0d got=%0d exp=%0d", d, low_cs, 33 * d * ncap); end
    n_checks++; if (sclk_hi != 16 * d * ncap) begin n_fail++;
      $display("FAIL sclk_high_cycles d=%0d got=%0d exp=%0d", d, sclk_hi, 16 * d * ncap); end
    m_cnt[s] = m_cnt[s] + 16'(ncap);
    m_word[s] = cap_words[ncap - 1];
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_checks++; if ({cs_n_a, sclk_a, sr_enable_a, sr_d_a, word_valid_a, busy_a} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl_a got=%b exp=100000",
                         {cs_n_a, sclk_a, sr_enable_a, sr_d_a, word_valid_a, busy_a}); end
    n_checks++; if ({word_out_a, word_count_a} !== 32'h0) begin
      n_fail++; $display("FAIL reset_words_a got=%h exp=0", {word_out_a, word_count_a}); end
    n_checks++; if ({cs_n_b, sclk_b, sr_enable_b, sr_d_b, word_valid_b, busy_b} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl_b got=%b exp=100000",
                         {cs_n_b, sclk_b, sr_enable_b, sr_d_b, word_valid_b, busy_b}); end
    n_checks++; if ({word_out_b, word_count_b} !== 32'h0) begin
      n_fail++; $display("FAIL reset_words_b got=%h exp=0", {word_out_b, word_count_b}); end
    m_cnt[0] = 0; m_cnt[1] = 0; m_word[0] = 0; m_word[1] = 0;
    reset = 0;
  endtask

  task automatic test_single_capture();
    cap_words[0] = 16'hA5C3;
    run_capture(0, 1, 1, 0, 0, -1, -1, 0, 5);
  endtask

  task automatic test_ignored_start();
    cap_words[0] = 16'hA5C3;
    run_capture(0, 1, 1, 0, 0, 10, 40, 0, 8);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      cap_words[0] = 16'($urandom);
      run_capture(0, 1, 1, 0, 0, -1, -1, 0, 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_continuous();
    for (int i = 0; i < 3; i++) cap_words[i] = 16'hFFFF;
    run_capture(0, 3, 0, 1, 2 * 69 + 30, -1, -1, 1, 6);
    for (int i = 0; i < 4; i++) cap_words[i] = 16'($urandom);
    run_capture(0, 4, 0, 1, 3 * 69 + 68, -1, -1, 0, 6);
  endtask

  task automatic test_both_high();
    cap_words[0] = 16'($urandom);
    run_capture(0, 1, 1, 1, 1, -1, -1, 0, 5);
  endtask

  task automatic test_reset_mid_shift();
    start_a = 1;
    for (int n = 0; n <= 30; n++) begin
      sdata = 1'($urandom);
      if (n == 1) start_a = 0;
      if (n >= 1) begin
        n_checks++; if (word_valid_a !== 1'b0) begin n_fail++;
          $display("FAIL pre_reset_valid n=%0d got=%b exp=0", n, word_valid_a); end
      end
      if (n == 30) reset = 1;
      @(negedge clk);
    end
    reset = 0;
    n_checks++; if ({cs_n_a, sclk_a, busy_a, word_valid_a, sr_enable_a} !== 5'b10000) begin
      n_fail++; $display("FAIL mid_reset_ctrl got=%b exp=10000",
                         {cs_n_a, sclk_a, busy_a, word_valid_a, sr_enable_a}); end
    n_checks++; if (word_count_a !== 16'h0) begin
      n_fail++; $display("FAIL mid_reset_count got=%h exp=0000", word_count_a); end
    n_checks++; if (word_out_a !== 16'h0) begin
      n_fail++; $display("FAIL mid_reset_word got=%h exp=0000", word_out_a); end
    m_cnt[0] = 0; m_cnt[1] = 0; m_word[0] = 0; m_word[1] = 0;
    cap_words[0] = 16'($urandom);
    run_capture(0, 1, 1, 0, 0, -1, -1, 0, 4);
  endtask

  task automatic test_counter_wrap();
    force dut_a.word_count = 16'hFFFF;
    @(negedge clk);
    release dut_a.word_count;
    @(negedge clk);
    n_checks++; if (word_count_a !== 16'hFFFF) begin
      n_fail++; $display("FAIL preload_count got=%h exp=ffff", word_count_a); end
    m_cnt[0] = 16'hFFFF;
    cap_words[0] = 16'($urandom);
    run_capture(0, 1, 1, 0, 0, -1, -1, 0, 3);
    n_checks++; if (word_count_a !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_count got=%h exp=0000", word_count_a); end
  endtask

  task automatic test_divider();
    for (int i = 0; i < 2; i++) begin
      cap_words[0] = 16'($urandom);
      run_capture(1, 1, 1, 0, 0, -1, -1, 0, 3);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_capture();
    test_ignored_start();
    test_back_to_back();
    test_continuous();
    test_both_high();
    test_reset_mid_shift();
    test_counter_wrap();
    test_divider();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
